alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Controller that loads the three operand latches of the ALU datapath (operand A, operand B, opcode) from a serial byte stream.
- Each received byte drives a shared latch data bus plus a one-cycle enable pulse for the target latch.
- After the opcode is loaded and the ALU has settled, the block samples the ALU result and starts a transmit, then waits for completion.
- Sits between the UART receiver/transmitter and the latch bank feeding the ALU.

Parameters:
- SIZE_DATA, 8, width of received bytes, latch data bus and ALU result.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clock cycles; used only when the optional feature is compiled in.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous active-high reset.
- i_rx_data  input  SIZE_DATA  received byte; valid while i_rx_done is high.
- i_rx_done  input  1  single-cycle pulse, byte received.
- i_alu_result  input  SIZE_DATA  combinational ALU output.
- i_tx_done  input  1  single-cycle pulse, transmit complete.
- o_latch_data  output  SIZE_DATA  registered data bus to all three latches.
- o_en_a  output  1  enable pulse for the operand A latch.
- o_en_b  output  1  enable pulse for the operand B latch.
- o_en_op  output  1  enable pulse for the opcode latch.
- o_tx_data  output  SIZE_DATA  registered ALU result for the transmitter.
- o_tx_start  output  1  single-cycle transmit start pulse.
- o_busy  output  1  high in S_SETTLE, S_SEND and S_WAIT_TX.
- o_overrun  output  1  single-cycle pulse, byte dropped.
- o_timeout  output  1  single-cycle pulse, frame aborted (optional feature).

Behaviour:
- Reset: asynchronous. State is S_A. All outputs are 0, including o_latch_data and o_tx_data.
- The block does not reset the latches; they have their own reset.
- States: S_A, S_B, S_OP, S_SETTLE, S_SEND, S_WAIT_TX.
- S_A, S_B, S_OP: on the edge where i_rx_done=1:
  - o_latch_data <= i_rx_data.
  - The matching enable (o_en_a, o_en_b or o_en_op) <= 1 for exactly one cycle.
  - State advances S_A->S_B->S_OP->S_SETTLE.
  - Latency: enable and data are visible the cycle after i_rx_done.
  - o_latch_data holds its value until the next accepted byte.
- S_SETTLE: lasts one cycle, during which o_en_op is high; then -> S_SEND.
- S_SEND: lasts one cycle.
  - o_tx_data <= i_alu_result and o_tx_start <= 1 (one cycle); then -> S_WAIT_TX.
  - o_tx_start is first high 3 cycles after the opcode's i_rx_done.
- S_WAIT_TX: on i_tx_done -> S_A.
- Byte during busy: i_rx_done in S_SETTLE, S_SEND or S_WAIT_TX drops the byte.
  - o_overrun pulses 1 cycle.
  - No enable asserts; o_latch_data and state are unchanged.
- i_tx_done is ignored outside S_WAIT_TX.
- Simultaneous i_rx_done and i_tx_done in S_WAIT_TX: the byte is dropped with o_overrun, and the state goes to S_A.
- Back-to-back i_rx_done on consecutive cycles is accepted; each byte gets its own enable pulse.
- At most one enable is high in any cycle.
- Reset mid-frame: immediate return to S_A; all pulses are cleared.

Optional Feature:
- Macro: ALU_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter of width $clog2(TIMEOUT_CYCLES+1) clears on every accepted byte and on entry to S_A.
  - It counts only in S_B and S_OP.
  - On reaching TIMEOUT_CYCLES: state -> S_A, o_timeout pulses 1 cycle, counter clears.
  - An i_rx_done arriving in that same cycle is accepted normally and takes priority over the timeout.
- Undefined: no counter is built; o_timeout is tied 0; the block waits indefinitely for bytes.

Test Plan:
- Reset:
  - Assert i_reset with no clock edge -> all outputs 0 immediately.
  - After release, first byte 0x11 -> o_en_a=1, o_latch_data=0x11.
- Full frame:
  - Bytes 0x05, 0x03, 0x20 with i_alu_result stub 0x08 -> o_en_a/o_en_b/o_en_op each high 1 cycle with data 0x05/0x03/0x20.
  - o_tx_start is high 3 cycles after the third i_rx_done with o_tx_data=0x08, and o_busy=1.
  - After i_tx_done, byte 0x01 -> o_en_a.
- Overrun: i_rx_done with data 0xFF during S_WAIT_TX -> o_overrun 1 cycle, no enable, o_latch_data still 0x20; after i_tx_done, normal operation.
- Reset mid-frame: async reset after the A and B bytes -> state S_A; next byte 0x07 -> o_en_a, not o_en_op.
- Back-to-back: i_rx_done on 3 consecutive cycles with 0x0A, 0x0B, 0x0C -> o_en_a, o_en_b, o_en_op on 3 consecutive cycles with matching data.
- Timeout (ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Byte A then silence -> o_timeout pulses 16 cycles after entering S_B; next byte -> o_en_a.
  - Without the macro: no o_timeout after 100 idle cycles; next byte -> o_en_b.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Loads operand A, operand B and opcode latches from a serial byte stream, then
// samples the ALU result and hands it to the transmitter. Optional inter-byte
// timeout is compiled in with the ALU_SEQ_TIMEOUT_EN macro.
module alu_operand_sequencer #(
   parameter int SIZE_DATA      = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [SIZE_DATA-1:0] i_rx_data,
   input  logic                 i_rx_done,
   input  logic [SIZE_DATA-1:0] i_alu_result,
   input  logic                 i_tx_done,
   output logic [SIZE_DATA-1:0] o_latch_data,
   output logic                 o_en_a,
   output logic                 o_en_b,
   output logic                 o_en_op,
   output logic [SIZE_DATA-1:0] o_tx_data,
   output logic                 o_tx_start,
   output logic                 o_busy,
   output logic                 o_overrun,
   output logic                 o_timeout
);

   typedef enum logic [2:0] {
      S_A       = 3'd0,
      S_B       = 3'd1,
      S_OP      = 3'd2,
      S_SETTLE  = 3'd3,
      S_SEND    = 3'd4,
      S_WAIT_TX = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [SIZE_DATA-1:0]   latch_data_q, latch_data_d;
   logic [SIZE_DATA-1:0]   tx_data_q, tx_data_d;
   logic                   en_a_q, en_a_d;
   logic                   en_b_q, en_b_d;
   logic                   en_op_q, en_op_d;
   logic                   tx_start_q, tx_start_d;
   logic                   busy_q, busy_d;
   logic                   overrun_q, overrun_d;
   logic                   timeout_q, timeout_d;
   logic                   timeout_hit_s;

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout_hit_s = ((state_q == S_B) || (state_q == S_OP)) &&
                          (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Idle counter: runs only while waiting for the B or opcode byte
   always_comb begin
      cnt_d = {CNT_W{1'b0}};
      if (((state_q == S_B) || (state_q == S_OP)) && !i_rx_done && !timeout_hit_s) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = {CNT_W{1'b0}};
      end
   end

   // Idle counter register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // Always false; referencing the parameter keeps both builds on one interface.
   assign timeout_hit_s = (TIMEOUT_CYCLES < 0);
`endif

   // Next-state and output pulse generation
   always_comb begin
      state_d      = state_q;
      latch_data_d = latch_data_q;
      tx_data_d    = tx_data_q;
      en_a_d       = 1'b0;
      en_b_d       = 1'b0;
      en_op_d      = 1'b0;
      tx_start_d   = 1'b0;
      overrun_d    = 1'b0;
      timeout_d    = 1'b0;
      case (state_q)
         S_A: begin
            if (i_rx_done) begin
               latch_data_d = i_rx_data;
               en_a_d       = 1'b1;
               state_d      = S_B;
            end else begin
               state_d      = S_A;
            end
         end
         S_B, S_OP: begin
            // An arriving byte wins over a timeout in the same cycle
            if (i_rx_done) begin
               latch_data_d = i_rx_data;
               en_b_d       = (state_q == S_B);
               en_op_d      = (state_q == S_OP);
               state_d      = (state_q == S_B) ? S_OP : S_SETTLE;
            end else if (timeout_hit_s) begin
               timeout_d    = 1'b1;
               state_d      = S_A;
            end else begin
               state_d      = state_q;
            end
         end
         S_SETTLE: begin
            overrun_d = i_rx_done;
            state_d   = S_SEND;
         end
         S_SEND: begin
            overrun_d  = i_rx_done;
            tx_data_d  = i_alu_result;
            tx_start_d = 1'b1;
            state_d    = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            overrun_d = i_rx_done;
            if (i_tx_done) begin
               state_d = S_A;
            end else begin
               state_d = S_WAIT_TX;
            end
         end
         default: begin
            state_d = S_A;
         end
      endcase
      busy_d = (state_d == S_SETTLE) || (state_d == S_SEND) || (state_d == S_WAIT_TX);
   end

   // State and registered outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= S_A;
         latch_data_q <= {SIZE_DATA{1'b0}};
         tx_data_q    <= {SIZE_DATA{1'b0}};
         en_a_q       <= 1'b0;
         en_b_q       <= 1'b0;
         en_op_q      <= 1'b0;
         tx_start_q   <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         latch_data_q <= latch_data_d;
         tx_data_q    <= tx_data_d;
         en_a_q       <= en_a_d;
         en_b_q       <= en_b_d;
         en_op_q      <= en_op_d;
         tx_start_q   <= tx_start_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
         timeout_q    <= timeout_d;
      end
   end

   assign o_latch_data = latch_data_q;
   assign o_en_a       = en_a_q;
   assign o_en_b       = en_b_q;
   assign o_en_op      = en_op_q;
   assign o_tx_data    = tx_data_q;
   assign o_tx_start   = tx_start_q;
   assign o_busy       = busy_q;
   assign o_overrun    = overrun_q;
   assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized bench for alu_operand_sequencer against a frame-level reference model
// (bytes accepted in the frame, cycles since the opcode, idle cycles).
module tb_alu_operand_sequencer;
`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1000000;
`endif

   logic       i_clk, i_reset;
   logic [7:0] i_rx_data, i_alu_result;
   logic       i_rx_done, i_tx_done;
   logic [7:0] o_latch_data, o_tx_data;
   logic       o_en_a, o_en_b, o_en_op, o_tx_start, o_busy, o_overrun, o_timeout;

   alu_operand_sequencer #(.SIZE_DATA(8), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
      .i_alu_result(i_alu_result), .i_tx_done(i_tx_done), .o_latch_data(o_latch_data),
      .o_en_a(o_en_a), .o_en_b(o_en_b), .o_en_op(o_en_op), .o_tx_data(o_tx_data),
      .o_tx_start(o_tx_start), .o_busy(o_busy), .o_overrun(o_overrun), .o_timeout(o_timeout)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   int vectors = 0;
   int miscompares = 0;

   // Reference model: bytes accepted in current frame, edges since opcode, idle edges
   int         m_got, m_age, m_idle;
   logic [7:0] m_latch, m_tx_data;
   bit         m_en_a, m_en_b, m_en_op, m_tx_start, m_busy, m_overrun, m_timeout;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_got = 0; m_age = 0; m_idle = 0;
      m_latch = 8'h00; m_tx_data = 8'h00;
      m_en_a = 1'b0; m_en_b = 1'b0; m_en_op = 1'b0; m_tx_start = 1'b0;
      m_busy = 1'b0; m_overrun = 1'b0; m_timeout = 1'b0;
   endtask

   task automatic model_step(input bit rx, input logic [7:0] rxd, input bit txd,
                             input logic [7:0] alu);
      m_en_a = 1'b0; m_en_b = 1'b0; m_en_op = 1'b0;
      m_tx_start = 1'b0; m_overrun = 1'b0; m_timeout = 1'b0;
      if (m_got == 3) begin
         if (rx) m_overrun = 1'b1;
         if (m_age == 0) m_age = 1;
         else if (m_age == 1) begin
            m_age = 2; m_tx_start = 1'b1; m_tx_data = alu;
         end else if (txd) m_got = 0;
      end else if (rx) begin
         m_latch = rxd;
         if (m_got == 0) m_en_a = 1'b1;
         else if (m_got == 1) m_en_b = 1'b1;
         else m_en_op = 1'b1;
         m_got++;
         m_idle = 0;
         if (m_got == 3) m_age = 0;
      end else if (m_got > 0) begin
`ifdef ALU_SEQ_TIMEOUT_EN
         m_idle++;
         if (m_idle == TO) begin
            m_got = 0; m_idle = 0; m_timeout = 1'b1;
         end
`endif
      end
      m_busy = (m_got == 3);
   endtask

   task automatic check_all(input string where);
      check_eq({where, ".latch_data"}, {24'd0, o_latch_data}, {24'd0, m_latch});
      check_eq({where, ".en_a"},       {31'd0, o_en_a},       {31'd0, m_en_a});
      check_eq({where, ".en_b"},       {31'd0, o_en_b},       {31'd0, m_en_b});
      check_eq({where, ".en_op"},      {31'd0, o_en_op},      {31'd0, m_en_op});
      check_eq({where, ".tx_data"},    {24'd0, o_tx_data},    {24'd0, m_tx_data});
      check_eq({where, ".tx_start"},   {31'd0, o_tx_start},   {31'd0, m_tx_start});
      check_eq({where, ".busy"},       {31'd0, o_busy},       {31'd0, m_busy});
      check_eq({where, ".overrun"},    {31'd0, o_overrun},    {31'd0, m_overrun});
      check_eq({where, ".timeout"},    {31'd0, o_timeout},    {31'd0, m_timeout});
   endtask

   // One clock cycle with the given inputs, then compare against the model
   task automatic cyc(input string where, input bit rx, input logic [7:0] rxd, input bit txd);
      i_rx_done = rx; i_rx_data = rxd; i_tx_done = txd;
      @(posedge i_clk);
      model_step(rx, rxd, txd, i_alu_result);
      #1;
      check_all(where);
   endtask

   task automatic idle(input string where, input int n);
      for (int k = 0; k < n; k++) cyc(where, 1'b0, 8'h00, 1'b0);
   endtask

   // Asynchronous reset between clock edges; outputs must clear before any edge
   task automatic do_reset(input string where);
      #2;
      i_reset = 1'b1;
      #1;
      model_reset();
      check_all(where);
      @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   initial begin
      i_reset = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
      i_tx_done = 1'b0; i_alu_result = 8'h08;
      model_reset();
      do_reset("por");

      cyc("first_a", 1'b1, 8'h11, 1'b0);
      do_reset("rst_after_a");

      cyc("frame_a", 1'b1, 8'h05, 1'b0);
      idle("frame_gap", 2);
      cyc("frame_b", 1'b1, 8'h03, 1'b0);
      cyc("frame_op", 1'b1, 8'h20, 1'b0);
      idle("frame_send", 4);
      cyc("overrun", 1'b1, 8'hFF, 1'b0);
      idle("overrun_hold", 2);
      cyc("tx_done", 1'b0, 8'h00, 1'b1);
      cyc("next_a", 1'b1, 8'h01, 1'b0);
      cyc("next_b", 1'b1, 8'h02, 1'b0);
      do_reset("rst_mid");
      cyc("after_rst_a", 1'b1, 8'h07, 1'b0);
      cyc("after_rst_b", 1'b1, 8'h08, 1'b0);
      cyc("after_rst_op", 1'b1, 8'h09, 1'b0);
      idle("wait_tx", 3);
      cyc("tx_done2", 1'b0, 8'h00, 1'b1);

      cyc("b2b_a", 1'b1, 8'h0A, 1'b0);
      cyc("b2b_b", 1'b1, 8'h0B, 1'b0);
      cyc("b2b_op", 1'b1, 8'h0C, 1'b0);
      idle("b2b_wait", 3);
      cyc("rx_tx_same", 1'b1, 8'h55, 1'b1);

      cyc("to_a", 1'b1, 8'h31, 1'b0);
      idle("to_idle", 100);
      cyc("to_next", 1'b1, 8'h32, 1'b0);
      do_reset("rst_pre_rand");

      for (int n = 0; n < 3000; n++) begin
         i_alu_result = 8'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            do_reset("rand_rst");
         end else begin
            cyc("rand", ($urandom_range(0, 9) < 4), 8'($urandom),
                (m_got == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0));
         end
         if ($urandom_range(0, 299) == 0) begin
            idle("rand_idle", 20);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
